// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary PC/instruction register with a two-entry skid buffer (optional stats: PIPE_STAGE_STATS_EN).
// Latency: 1 cycle from in_fire to out_valid; sustains one transfer per cycle.
// Backpressure: a stalled output parks one extra entry in the skid slot; in_ready drops only when both slots are full.
module pipe_stage_reg #(
    parameter int unsigned          PC_W        = 32,
    parameter int unsigned          INSTR_W     = 32,
    parameter logic [PC_W-1:0]      FLUSH_PC    = '0,
    parameter logic [INSTR_W-1:0]   FLUSH_INSTR = '0,
    parameter int unsigned          CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                freeze,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PC_W-1:0]     pc_in,
    input  logic [INSTR_W-1:0]  instr_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_W-1:0]     pc,
    output logic [INSTR_W-1:0]  instruction,
    output logic [1:0]          occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [PC_W-1:0]      skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
    logic                 in_fire;
    logic                 out_fire;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_stage_reg: CNT_W must be at least 1");
    end

    // rst gates in_ready so nothing is accepted while the stage is held in reset.
    assign in_ready    = rst & (state_q != FULL) & ~freeze & ~flush;
    assign out_valid   = (state_q != EMPTY);
    assign in_fire     = in_valid & in_ready;
    assign out_fire    = out_valid & out_ready & ~freeze & ~flush;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign occupancy   = state_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if (flush) begin
            state_d = EMPTY;
            pc_d    = FLUSH_PC;
            instr_d = FLUSH_INSTR;
        end else if (!freeze) begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        pc_d    = pc_in;
                        instr_d = instr_in;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        pc_d    = pc_in;
                        instr_d = instr_in;
                    end else if (in_fire) begin
                        state_d      = FULL;
                        skid_pc_d    = pc_in;
                        skid_instr_d = instr_in;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = ONE;
                        pc_d    = skid_pc_q;
                        instr_d = skid_instr_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= EMPTY;
            pc_q         <= FLUSH_PC;
            instr_q      <= FLUSH_INSTR;
            skid_pc_q    <= FLUSH_PC;
            skid_instr_q <= FLUSH_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters saturate and survive flush; only reset clears them.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, hand-written reset corner cases and a queue-model random run.
module tb_pipe_stage_reg;

    localparam logic [31:0] FPC = 32'h0000_0100;
    localparam logic [31:0] FIN = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, freeze, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] pc_in, instr_in, pc, instruction;
    logic [1:0]  occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [3:0]  stall_cnt, flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    pipe_stage_reg #(
        .PC_W(32), .INSTR_W(32), .FLUSH_PC(FPC), .FLUSH_INSTR(FIN), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .in_valid(in_valid), .in_ready(in_ready), .pc_in(pc_in), .instr_in(instr_in),
        .out_valid(out_valid), .out_ready(out_ready), .pc(pc), .instruction(instruction),
        .occupancy(occupancy)
`ifdef PIPE_STAGE_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] p);
        return (p == FPC) ? FIN : ~p;
    endfunction

    typedef struct {
        logic        fl, fz, iv;
        logic [31:0] pcv;
        logic        ordy;
        logic        e_rdy, e_vld;
        logic [31:0] e_pc;
        logic [1:0]  e_occ;
    } vec_t;

    typedef struct {
        logic [31:0] p;
        logic [31:0] i;
    } item_t;

    vec_t  tbl[$];
    item_t mq[$];
    item_t hold, it;

    function automatic vec_t mk(input logic fl, fz, iv, input logic [31:0] pcv, input logic ordy,
                                input logic e_rdy, e_vld, input logic [31:0] e_pc, input logic [1:0] e_occ);
        vec_t v;
        v.fl = fl; v.fz = fz; v.iv = iv; v.pcv = pcv; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_pc = e_pc; v.e_occ = e_occ;
        return v;
    endfunction

    logic        fl, fz, iv, ordy, e_rdy, fired, pend;
    logic [31:0] pcv, inv;

    initial begin
        // Stream, backpressure, freeze-while-full, flush-while-frozen, refill.
        tbl.push_back(mk(0,0,1,32'h00,1, 1,1,32'h00,1));
        tbl.push_back(mk(0,0,1,32'h04,1, 1,1,32'h04,1));
        tbl.push_back(mk(0,0,1,32'h08,1, 1,1,32'h08,1));
        tbl.push_back(mk(0,0,0,32'h08,1, 1,0,32'h08,0));
        tbl.push_back(mk(0,0,1,32'h10,0, 1,1,32'h10,1));
        tbl.push_back(mk(0,0,1,32'h14,0, 1,1,32'h10,2));
        tbl.push_back(mk(0,0,1,32'h18,0, 0,1,32'h10,2));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(0,1,1,32'h18,1, 0,1,32'h10,2));
        tbl.push_back(mk(0,0,1,32'h18,1, 0,1,32'h14,1));
        tbl.push_back(mk(0,0,1,32'h18,1, 1,1,32'h18,1));
        tbl.push_back(mk(0,0,1,32'h1C,0, 1,1,32'h18,2));
        tbl.push_back(mk(1,1,1,32'h20,1, 0,0,FPC,0));
        tbl.push_back(mk(0,0,0,32'h20,1, 1,0,FPC,0));
        tbl.push_back(mk(0,0,1,32'h30,0, 1,1,32'h30,1));
        tbl.push_back(mk(0,0,1,32'h34,0, 1,1,32'h30,2));

        rst = 1'b0; flush = 0; freeze = 0; out_ready = 0;
        in_valid = 1; pc_in = 32'h0; instr_in = instr_of(32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_pc", pc, FPC);
        chk("rst_instr", instruction, FIN);
        chk("rst_occ", {30'b0, occupancy}, 0);
        chk("rst_in_ready", {31'b0, in_ready}, 0);
        rst = 1'b1;

        foreach (tbl[r]) begin
            flush = tbl[r].fl; freeze = tbl[r].fz; in_valid = tbl[r].iv;
            pc_in = tbl[r].pcv; instr_in = instr_of(tbl[r].pcv); out_ready = tbl[r].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", r), {31'b0, in_ready}, {31'b0, tbl[r].e_rdy});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", r), {31'b0, out_valid}, {31'b0, tbl[r].e_vld});
            chk($sformatf("vec%0d_pc", r), pc, tbl[r].e_pc);
            chk($sformatf("vec%0d_instr", r), instruction, instr_of(tbl[r].e_pc));
            chk($sformatf("vec%0d_occ", r), {30'b0, occupancy}, {30'b0, tbl[r].e_occ});
        end

        // Asynchronous reset while FULL, between clock edges.
        flush = 0; freeze = 0; in_valid = 1; pc_in = 32'h38; instr_in = instr_of(32'h38); out_ready = 0;
        #3;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 0);
        chk("arst_occ", {30'b0, occupancy}, 0);
        chk("arst_pc", pc, FPC);
        chk("arst_instr", instruction, FIN);
        chk("arst_in_ready", {31'b0, in_ready}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 0;
        @(posedge clk);
        #1;
        chk("arst_after_occ", {30'b0, occupancy}, 0);
        chk("arst_after_pc", pc, FPC);

        // Random run against a queue model of the two-slot stage.
        mq.delete();
        hold.p = FPC; hold.i = FIN;
        pend = 0; iv = 0; pcv = 0; inv = 0;
        for (int c = 0; c < 400; c++) begin
            fl   = ($urandom % 16) == 0;
            fz   = ($urandom % 8) == 0;
            ordy = ($urandom % 4) != 0;
            if (!pend) begin
                iv  = ($urandom % 3) != 0;
                pcv = $urandom;
                inv = $urandom;
            end
            flush = fl; freeze = fz; out_ready = ordy; in_valid = iv; pc_in = pcv; instr_in = inv;
            #1;
            e_rdy = (mq.size() < 2) && !fl && !fz;
            chk("rnd_in_ready", {31'b0, in_ready}, {31'b0, e_rdy});
            chk("rnd_out_valid", {31'b0, out_valid}, {31'b0, (mq.size() > 0)});
            chk("rnd_pc", pc, (mq.size() > 0) ? mq[0].p : hold.p);
            chk("rnd_instr", instruction, (mq.size() > 0) ? mq[0].i : hold.i);
            chk("rnd_occ", {30'b0, occupancy}, mq.size());
            fired = iv && e_rdy;
            if (fl) begin
                mq.delete();
                hold.p = FPC; hold.i = FIN;
            end else if (!fz) begin
                if ((mq.size() > 0) && ordy) hold = mq.pop_front();
                if (fired) begin
                    it.p = pcv; it.i = inv;
                    mq.push_back(it);
                end
            end
            pend = iv && !fired;
            @(posedge clk);
            #1;
        end

`ifdef PIPE_STAGE_STATS_EN
        flush = 0; freeze = 0; in_valid = 0; out_ready = 0;
        rst = 1'b0;
        #2;
        chk("stats_rst_stall", {28'b0, stall_cnt}, 0);
        chk("stats_rst_flush", {28'b0, flush_cnt}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        freeze = 1; in_valid = 1; pc_in = 32'h40; instr_in = instr_of(32'h40);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 13) chk("stats_stall_14", {28'b0, stall_cnt}, 14);
        end
        chk("stats_stall_sat", {28'b0, stall_cnt}, 15);
        freeze = 0; in_valid = 0;
        for (int k = 0; k < 3; k++) begin
            flush = 1;
            @(posedge clk);
            #1;
            flush = 0;
            @(posedge clk);
            #1;
        end
        chk("stats_flush_cnt", {28'b0, flush_cnt}, 3);
        chk("stats_stall_kept", {28'b0, stall_cnt}, 15);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-boundary register; successor to the fixed 32-bit IF/ID stage register.
- Carries a PC/instruction pair between pipeline stages with a valid/ready handshake.
- Has a two-entry skid buffer, so backpressure never drops or duplicates a fetched instruction.
- Keeps freeze (stall) and flush (branch/hazard squash) controls, with configurable flush values.
- Used between the IF and ID stages, and reusable at any later stage boundary.

Parameters:
- PC_W, 32, width of the PC field.
- INSTR_W, 32, width of the instruction field.
- FLUSH_PC, 0, PC value loaded on reset and on flush.
- FLUSH_INSTR, 0, instruction value loaded on reset and on flush (NOP encoding).
- CNT_W, 16, statistics counter width (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash; highest priority after reset.
- freeze  in  1  synchronous stall; holds all state.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  stage can accept; combinational from state and freeze.
- pc_in  in  PC_W  upstream PC.
- instr_in  in  INSTR_W  upstream instruction.
- out_valid  out  1  registered output valid.
- out_ready  in  1  downstream accepts.
- pc  out  PC_W  registered output PC.
- instruction  out  INSTR_W  registered output instruction.
- occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready & ~freeze & ~flush.
  - in_valid and its data must stay stable until in_fire; out_valid/pc/instruction likewise until out_fire.
- Storage: a main entry (drives pc/instruction/out_valid) and a skid entry (internal).
- State machine (EMPTY=0, ONE=1, FULL=2; occupancy equals the state code):
  - EMPTY: in_fire -> ONE, main<=input.
  - ONE:
    - in_fire & out_fire -> ONE, main<=input.
    - in_fire & ~out_fire -> FULL, skid<=input.
    - out_fire only -> EMPTY.
    - otherwise hold.
  - FULL:
    - out_fire -> ONE, main<=skid.
    - otherwise hold.
  - No input is accepted in FULL.
- in_ready = (state!=FULL) & ~freeze & ~flush.
- Latency: 1 cycle from in_fire in EMPTY to out_valid=1. Sustained throughput is 1 transfer per cycle.
- pc/instruction hold their last value when out_valid=0. They are never updated by a non-firing input.
- Freeze: state, main, skid and outputs all hold; in_ready=0; no out_fire. Freeze held indefinitely loses nothing.
- Flush: on the next edge, state->EMPTY, skid discarded, pc<=FLUSH_PC, instruction<=FLUSH_INSTR, out_valid<=0. Flush overrides freeze. Input presented during a flush cycle is not accepted (in_ready=0).
- Reset (rst=0, asynchronous): state=EMPTY, out_valid=0, pc=FLUSH_PC, instruction=FLUSH_INSTR, occupancy=0, in_ready=0 while asserted. Reset mid-transfer drops both entries. First in_fire is possible in the cycle after rst deasserts.
- Widths are passed through unmodified. No arithmetic on data.

Optional Feature:
- Macro PIPE_STAGE_STATS_EN.
- When defined, adds outputs stall_cnt [CNT_W] and flush_cnt [CNT_W]:
  - stall_cnt increments each cycle with in_valid & ~in_ready.
  - flush_cnt increments each cycle with flush=1.
  - Both saturate at all-ones, reset to 0 on rst, and are not cleared by flush.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then stream: rst low 3 cycles; then in_valid=1 with pc_in=0x0,0x4,0x8 and out_ready=1 -> out_valid rises 1 cycle after first in_fire; pc=0x0,0x4,0x8 on consecutive cycles; occupancy=1; outputs before first fire are FLUSH_PC/FLUSH_INSTR.
- Backpressure: out_ready=0, send pc 0x10, 0x14 -> occupancy goes 1 then 2, in_ready=0; raise out_ready -> pc 0x10 then 0x14 delivered in order, no duplicates or losses.
- Freeze while FULL: hold freeze=1 for 5 cycles with out_ready=1 and in_valid=1 -> occupancy stays 2, pc unchanged, in_ready=0; release -> draining resumes in order.
- Flush while FULL and frozen: flush=1 and freeze=1 together -> next cycle out_valid=0, occupancy=0, pc=FLUSH_PC, instruction=FLUSH_INSTR; an in_valid pc 0x20 during the flush is not accepted.
- Async reset mid-operation: assert rst between clock edges with occupancy=2 -> outputs go to reset values immediately without waiting for clk.
- With PIPE_STAGE_STATS_EN, CNT_W=4: 20 stall cycles -> stall_cnt saturates at 15; 3 flush pulses -> flush_cnt=3.
